// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard detection unit.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hazard_state_e;

  // Number of bubbles a hazard needs: 0, 1 or 2.
  typedef logic [1:0] stall_cnt_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_src_match.sv
// Combinational check: does a producer destination feed a source operand of the ID instruction.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] dst,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             uses_rt,
  output logic             hit
);

  // $zero is hard-wired, so it never carries a dependency.
  assign hit = (dst != REG_W'(REG_ZERO)) &&
               ((dst == rs) || (uses_rt && (dst == rt)));

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / branch hazard detector: zero-latency Stall plus PC and IF/ID freeze enables.
// Optional stall statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [REG_W-1:0] ID_EX_WriteReg,
  input  logic             EX_MEM_MemRead,
  input  logic [REG_W-1:0] EX_MEM_WriteReg,
  output logic             Stall,
  output logic             PCWrite,
  output logic             IF_IDWrite
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] hazard_events
`endif
);

  hazard_state_e state_q;
  hazard_state_e state_d;
  stall_cnt_t    need_n;
  logic          hit_ex;
  logic          hit_mem;
  logic          stall_int;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  hazard_src_match #(.REG_W(REG_W)) u_match_ex (
    .dst     (ID_EX_WriteReg),
    .rs      (IF_ID_Rs),
    .rt      (IF_ID_Rt),
    .uses_rt (ID_UsesRt),
    .hit     (hit_ex)
  );

  hazard_src_match #(.REG_W(REG_W)) u_match_mem (
    .dst     (EX_MEM_WriteReg),
    .rs      (IF_ID_Rs),
    .rt      (IF_ID_Rt),
    .uses_rt (ID_UsesRt),
    .hit     (hit_mem)
  );

  // Branches compare in ID, so they also wait on ALU results and loads still in MEM.
  always_comb begin
    need_n = 2'd0;
    if (ID_Branch) begin
      if (ID_EX_MemRead && hit_ex) begin
        need_n = 2'd2;
      end else if (ID_EX_RegWrite && hit_ex) begin
        need_n = 2'd1;
      end else if (EX_MEM_MemRead && hit_mem) begin
        need_n = 2'd1;
      end
    end else if (ID_EX_MemRead && hit_ex) begin
      need_n = 2'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_int = 1'b0;
    unique case (state_q)
      RUN: begin
        stall_int = (need_n != 2'd0);
        if (need_n == 2'd2) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        stall_int = 1'b1;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      stall_int = 1'b0;
      state_d   = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign Stall      = stall_int;
  assign PCWrite    = ~stall_int;
  assign IF_IDWrite = ~stall_int;

`ifdef HAZARD_STATS_EN
  logic run_hazard;

  assign run_hazard = (state_q == RUN) && (need_n != 2'd0);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      hazard_events <= '0;
    end else begin
      if (stall_int && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (run_hazard && (hazard_events != '1)) begin
        hazard_events <= hazard_events + 1'b1;
      end
    end
  end
`endif

endmodule
